// File: rtl/dpram_bist_pkg.sv
// dpram_bist_pkg: shared states, pattern codes, LFSR taps and pattern-order helper for the DPRAM BIST
package dpram_bist_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
  localparam logic [1:0] PAT_ZERO = 2'd0;
  localparam logic [1:0] PAT_ONE  = 2'd1;
  localparam logic [1:0] PAT_LFSR = 2'd2;
  localparam logic [1:0] PAT_ADDR = 2'd3;
  localparam int LFSR_TAP_HI = 35;
  localparam int LFSR_TAP_LO = 24;
  localparam logic [15:0] ERR_SAT = 16'hFFFF;
  // Lowest enabled pattern at or above lo, as {found, code}.
  function automatic logic [2:0] pick_pat(input logic [3:0] m, input int lo);
    pick_pat = '0;
    for (int i = 3; i >= 0; i--)
      if (m[i] && i >= lo) pick_pat = {1'b1, 2'(i)};
  endfunction
endpackage

// File: rtl/dpram_bist_if.sv
// dpram_bist_if: BIST-to-RAM pins; master = BIST controller (A read, B write), slave = RAM
interface dpram_bist_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 36
) ();
  logic [AWIDTH-1:0] ram_addr_a;
  logic              ram_rce_a;
  logic [DWIDTH-1:0] ram_rq_a;
  logic [AWIDTH-1:0] ram_addr_b;
  logic              ram_wce_b;
  logic [DWIDTH-1:0] ram_wd_b;
  modport master (output ram_addr_a, ram_rce_a, ram_addr_b, ram_wce_b, ram_wd_b, input ram_rq_a);
  modport slave  (input ram_addr_a, ram_rce_a, ram_addr_b, ram_wce_b, ram_wd_b, output ram_rq_a);
endinterface

// File: rtl/dpram_bist_patgen.sv
// dpram_bist_patgen: test-word generator (pat, addr, step, reseed) -> data
//   clock0/reset_n : clock, async active-low reset
//   pat, addr      : pattern code and current word address
//   step, reseed   : advance the LFSR one word / reload it with the seed (reseed wins)
//   data           : pattern word for this cycle
module dpram_bist_patgen
  import dpram_bist_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 36,
  parameter logic [DWIDTH-1:0] LFSR_SEED = 36'h0_ACE1_F00D
) (
  input  logic              clock0,
  input  logic              reset_n,
  input  logic [1:0]        pat,
  input  logic [AWIDTH-1:0] addr,
  input  logic              step,
  input  logic              reseed,
  output logic [DWIDTH-1:0] data
);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [DWIDTH-1:0] SEED = (LFSR_SEED == '0) ? DWIDTH'(1) : LFSR_SEED;
  logic [DWIDTH-1:0] lfsr;
  always_ff @(posedge clock0 or negedge reset_n)
    if (!reset_n) lfsr <= SEED;
    else if (reseed) lfsr <= SEED;
    else if (step) lfsr <= {lfsr[DWIDTH-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
  assign data = pat == PAT_ZERO ? '0 :
                pat == PAT_ONE  ? '1 :
                pat == PAT_LFSR ? lfsr : {{(DWIDTH-2*AWIDTH){1'b0}}, ~addr, addr};
endmodule

// File: rtl/dpram_bist_ctrl.sv
// dpram_bist_ctrl: BIST initiator for the 36x1024 DPRAM, writes patterns on port B and checks them on port A
//   clock0/reset_n        : clock, async active-low reset
//   start, pat_mask       : run request (IDLE only) and enabled patterns (zeros, ones, LFSR, addr)
//   busy, done, pass      : run in progress, end-of-run pulse, result (err_count==0)
//   err_count             : saturating mismatch count
//   first_fail_addr/data  : address and read data of the first mismatch
//   ram                   : RAM pins (master modport)
module dpram_bist_ctrl
  import dpram_bist_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 36,
  parameter int SIZE = 1024,
  parameter int RD_LATENCY = 1,
  parameter logic [DWIDTH-1:0] LFSR_SEED = 36'h0_ACE1_F00D
) (
  input  logic              clock0,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        pat_mask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [AWIDTH-1:0] first_fail_addr,
  output logic [DWIDTH-1:0] first_fail_data,
  dpram_bist_if.master      ram
);
  state_t state, state_n;
  logic [AWIDTH-1:0] addr, addr_n;
  logic [1:0] pat, pat_n;
  logic [3:0] mask;
  logic [2:0] pick;
  logic fin, launch, last, step, reseed, mis;
  logic [DWIDTH-1:0] pdata;
  logic [RD_LATENCY-1:0] vld_q;
  logic [AWIDTH-1:0] adr_q [RD_LATENCY];
  logic [DWIDTH-1:0] exp_q [RD_LATENCY];
  assign launch = state == S_IDLE && start;
  assign last = addr == AWIDTH'(SIZE - 1);
  // addr doubles as the DRAIN cycle counter.
  always_comb begin
    state_n = state;
    addr_n = addr;
    pat_n = pat;
    pick = '0;
    unique case (state)
      S_IDLE: if (start) begin
        pick = pick_pat(pat_mask, 0);
        state_n = pick[2] ? S_WRITE : S_DONE;
        pat_n = pick[1:0];
        addr_n = '0;
      end
      S_WRITE: begin
        addr_n = last ? '0 : addr + 1'b1;
        state_n = last ? S_READ : S_WRITE;
      end
      S_READ: begin
        addr_n = last ? '0 : addr + 1'b1;
        state_n = last ? S_DRAIN : S_READ;
      end
      S_DRAIN: begin
        addr_n = addr + 1'b1;
        if (addr == AWIDTH'(RD_LATENCY - 1)) begin
          pick = pick_pat(mask, int'(pat) + 1);
          addr_n = '0;
          state_n = pick[2] ? S_WRITE : S_DONE;
          pat_n = pick[2] ? pick[1:0] : pat;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock0 or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      addr <= '0;
      pat <= PAT_ZERO;
      mask <= '0;
      fin <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      pat <= pat_n;
      mask <= launch ? pat_mask : mask;
      fin <= state_n == S_DONE || (fin && !launch);
    end
  // The LFSR restarts on entry to WRITE and READ so both phases see the same sequence.
  assign step = state == S_WRITE || state == S_READ;
  assign reseed = state_n != state && (state_n == S_WRITE || state_n == S_READ);
  dpram_bist_patgen #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .LFSR_SEED(LFSR_SEED)) u_patgen (
    .clock0, .reset_n, .pat, .addr, .step, .reseed, .data(pdata)
  );
  assign ram.ram_wce_b = state == S_WRITE;
  assign ram.ram_rce_a = state == S_READ;
  assign ram.ram_addr_b = ram.ram_wce_b ? addr : '0;
  assign ram.ram_wd_b = ram.ram_wce_b ? pdata : '0;
  assign ram.ram_addr_a = ram.ram_rce_a ? addr : '0;
  // Expected word and address travel alongside the RAM read latency.
  always_ff @(posedge clock0 or negedge reset_n)
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        adr_q[i] <= '0;
        exp_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= ram.ram_rce_a;
      adr_q[0] <= addr;
      exp_q[0] <= pdata;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  // Case inequality so X/Z read data is a mismatch.
  assign mis = vld_q[RD_LATENCY-1] && (ram.ram_rq_a !== exp_q[RD_LATENCY-1]);
  always_ff @(posedge clock0 or negedge reset_n)
    if (!reset_n) begin
      err_count <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else if (launch) begin
      err_count <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else if (mis) begin
      if (err_count == '0) begin
        first_fail_addr <= adr_q[RD_LATENCY-1];
        first_fail_data <= ram.ram_rq_a;
      end
      err_count <= err_count == ERR_SAT ? err_count : err_count + 16'd1;
    end
  assign busy = state inside {S_WRITE, S_READ, S_DRAIN};
  assign done = state == S_DONE;
  assign pass = fin && err_count == '0;
endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// tb_dpram_bist_ctrl: table-driven and directed checks of dpram_bist_ctrl against a faultable RAM model
module tb_dpram_bist_ctrl;
  localparam logic [35:0] SEED = 36'h0_ACE1_F00D;
  typedef struct {
    logic [3:0]  mask;
    int          faddr;
    logic [35:0] sa1;
    logic [35:0] sa0;
    int          cyc;
    int          err;
    logic        pas;
    logic [9:0]  fa;
    logic [35:0] fd;
  } vec_t;
  logic clock0 = 1'b0;
  logic reset_n = 1'b0;
  logic start [2];
  logic [3:0] pat_mask [2];
  logic busy [2];
  logic done [2];
  logic pass [2];
  logic [15:0] err_count [2];
  logic [9:0] ffa [2];
  logic [35:0] ffd [2];
  int f_addr = -1;
  logic [35:0] f_sa1 = '0;
  logic [35:0] f_sa0 = '0;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t v [6];
  always #5 clock0 = ~clock0;
  for (genvar g = 0; g < 2; g++) begin : g_u
    dpram_bist_if #(.AWIDTH(10), .DWIDTH(36)) rif ();
    logic [35:0] mem [1024];
    logic [35:0] rd0, rd1, word;
    int en_seen = 0;
    int both_on = 0;
    dpram_bist_ctrl #(.RD_LATENCY(g + 1), .LFSR_SEED(SEED)) u_dut (
      .clock0, .reset_n, .start(start[g]), .pat_mask(pat_mask[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .err_count(err_count[g]),
      .first_fail_addr(ffa[g]), .first_fail_data(ffd[g]), .ram(rif.master)
    );
    always_comb begin
      word = mem[rif.ram_addr_a];
      if (int'(rif.ram_addr_a) == f_addr) word = word | f_sa1;
      word = word & ~f_sa0;
    end
    always @(posedge clock0) begin
      if (rif.ram_wce_b) mem[rif.ram_addr_b] <= rif.ram_wd_b;
      rd0 <= rif.ram_rce_a ? word : '0;
      rd1 <= rd0;
    end
    assign rif.ram_rq_a = g == 0 ? rd0 : rd1;
    always @(negedge clock0) begin
      if (rif.ram_wce_b && rif.ram_rce_a) both_on++;
      if (rif.ram_wce_b || rif.ram_rce_a) en_seen++;
    end
  end
  function automatic logic [35:0] lfsr_next(input logic [35:0] s);
    return {s[34:0], s[35] ^ s[24]};
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic run0(input logic [3:0] m, output int n);
    pat_mask[0] = m;
    start[0] = 1'b1;
    @(posedge clock0);
    #1 start[0] = 1'b0;
    n = 1;
    while (!done[0] && n < 20000) begin
      @(posedge clock0);
      #1 n++;
    end
  endtask
  initial begin
    int ones35, n, e0, widx, lmis, k;
    logic [35:0] s, first;
    start = '{1'b0, 1'b0};
    pat_mask = '{4'h0, 4'h0};
    s = SEED;
    ones35 = 0;
    for (int i = 0; i < 1024; i++) begin
      ones35 += int'(s[35]);
      s = lfsr_next(s);
    end
    v[0] = '{4'b0011, -1,   36'h0, 36'h0,           4099, 0,            1'b1, 10'd0,    36'h0};
    v[1] = '{4'b0001, 5,    36'h1, 36'h0,           2050, 1,            1'b0, 10'd5,    36'h1};
    v[2] = '{4'b1111, -1,   36'h0, 36'h8_0000_0000, 8197, 1024 + ones35, 1'b0, 10'd0,   36'h7_FFFF_FFFF};
    v[3] = '{4'b0000, -1,   36'h0, 36'h0,           1,    0,            1'b1, 10'd0,    36'h0};
    v[4] = '{4'b1000, 0,    36'h1, 36'h0,           2050, 1,            1'b0, 10'd0,    36'h0_000F_FC01};
    v[5] = '{4'b0001, 1023, 36'h8, 36'h0,           2050, 1,            1'b0, 10'd1023, 36'h8};
    repeat (3) @(posedge clock0);
    #1;
    chk("rst_status", {busy[0], done[0], pass[0], err_count[0], ffa[0]}, '0);
    chk("rst_ffd", ffd[0], '0);
    chk("rst_ram", {g_u[0].rif.ram_wce_b, g_u[0].rif.ram_rce_a, g_u[0].rif.ram_addr_a,
                    g_u[0].rif.ram_addr_b, g_u[0].rif.ram_wd_b}, '0);
    reset_n = 1'b1;
    @(posedge clock0);
    #1;
    for (int i = 0; i < 6; i++) begin
      f_addr = v[i].faddr;
      f_sa1 = v[i].sa1;
      f_sa0 = v[i].sa0;
      e0 = g_u[0].en_seen;
      run0(v[i].mask, n);
      chk($sformatf("v%0d_cycles", i), n, v[i].cyc);
      chk($sformatf("v%0d_busy", i), busy[0], 1'b0);
      chk($sformatf("v%0d_err", i), err_count[0], v[i].err);
      chk($sformatf("v%0d_pass", i), pass[0], v[i].pas);
      chk($sformatf("v%0d_ffa", i), ffa[0], v[i].fa);
      chk($sformatf("v%0d_ffd", i), ffd[0], v[i].fd);
      chk($sformatf("v%0d_enables", i), g_u[0].en_seen - e0, 2048 * $countones(v[i].mask));
      @(posedge clock0);
      #1;
      chk($sformatf("v%0d_done_pulse", i), done[0], 1'b0);
      chk($sformatf("v%0d_pass_hold", i), pass[0], v[i].pas);
    end
    f_addr = -1;
    f_sa1 = '0;
    f_sa0 = '0;
    pat_mask[1] = 4'b0100;
    start[1] = 1'b1;
    @(posedge clock0);
    #1 start[1] = 1'b0;
    n = 1;
    widx = 0;
    lmis = 0;
    first = '0;
    s = SEED;
    while (!done[1] && n < 5000) begin
      if (g_u[1].rif.ram_wce_b) begin
        if (widx == 0) first = g_u[1].rif.ram_wd_b;
        if (g_u[1].rif.ram_wd_b !== s) lmis++;
        s = lfsr_next(s);
        widx++;
      end
      @(posedge clock0);
      #1 n++;
    end
    chk("lfsr_first_word", first, SEED);
    chk("lfsr_seq_mismatches", lmis, 0);
    chk("lfsr_words", widx, 1024);
    chk("lfsr_cycles", n, 2051);
    chk("lfsr_pass", pass[1], 1'b1);
    chk("lfsr_err", err_count[1], 16'd0);
    pat_mask[0] = 4'b0011;
    start[0] = 1'b1;
    @(posedge clock0);
    #1 start[0] = 1'b0;
    k = 0;
    while (!(g_u[0].rif.ram_wce_b && g_u[0].rif.ram_addr_b == 10'd300) && k < 2000) begin
      @(posedge clock0);
      #1 k++;
    end
    chk("reach_w300", g_u[0].rif.ram_wce_b && g_u[0].rif.ram_addr_b == 10'd300, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_status", {busy[0], done[0], pass[0], err_count[0], ffa[0]}, '0);
    chk("midrst_ffd", ffd[0], '0);
    chk("midrst_ram", {g_u[0].rif.ram_wce_b, g_u[0].rif.ram_rce_a, g_u[0].rif.ram_addr_a,
                       g_u[0].rif.ram_addr_b, g_u[0].rif.ram_wd_b}, '0);
    @(posedge clock0);
    #1 reset_n = 1'b1;
    @(posedge clock0);
    #1;
    pat_mask[0] = 4'b0001;
    start[0] = 1'b1;
    @(posedge clock0);
    #1 start[0] = 1'b0;
    n = 1;
    while (!done[0] && n < 20000) begin
      start[0] = n == 100 || n == 1500;
      pat_mask[0] = n >= 10 ? 4'b1111 : 4'b0001;
      @(posedge clock0);
      #1 n++;
    end
    start[0] = 1'b0;
    pat_mask[0] = 4'b0000;
    chk("rerun_cycles", n, 2050);
    chk("rerun_pass", pass[0], 1'b1);
    chk("rerun_err", err_count[0], 16'd0);
    chk("no_overlap", g_u[0].both_on + g_u[1].both_on, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
